aes_encrypt_ctrl: RTL and testbench

// Iterative AES-128 encryption sequencer. Accepts one plaintext/key pair over a valid/ready

---
 rtl/aes_encrypt_ctrl.sv | 124 ++++++++++++
 tb/tb_aes_encrypt_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_ctrl.sv
// Iterative AES-128 encryption sequencer: owns the state and round-key registers and steps
// external combinational round / key-expansion units through rounds 1..10.
module aes_encrypt_ctrl #(
    parameter int unsigned DP_WAIT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_pt,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_ct,
    output logic [127:0] dp_state,
    output logic [127:0] dp_key,
    output logic         dp_final,
    input  logic [127:0] dp_result,
    output logic [127:0] ks_key,
    output logic [7:0]   ks_rcon,
    input  logic [127:0] ks_next,
    output logic [3:0]   round,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    fsm_t         fsm;
    fsm_t         fsm_next;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [127:0] ct_reg;
    logic [3:0]   round_reg;
    logic [2:0]   wait_cnt;
    logic         accept;
    logic         capture;
    logic         last_round;
    logic         handoff;

    always_comb begin
        accept     = (fsm == IDLE) && in_valid;
        capture    = (fsm == RUN) && (wait_cnt == 3'(DP_WAIT));
        last_round = capture && (round_reg == 4'd10);
        handoff    = (fsm == DONE) && out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (accept)     fsm_next = RUN;
            RUN:     if (last_round) fsm_next = DONE;
            DONE:    if (handoff)    fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    // out_valid is exactly "in DONE": it is set by the final capture and cleared by the handoff.
    always_comb begin
        in_ready  = (fsm == IDLE);
        busy      = (fsm == RUN);
        out_valid = (fsm == DONE);
        dp_final  = (round_reg == 4'd10);
        dp_state  = state_reg;
        dp_key    = ks_next;
        ks_key    = key_reg;
        out_ct    = ct_reg;
        round     = round_reg;
        case (round_reg)
            4'd1:    ks_rcon = 8'h01;
            4'd2:    ks_rcon = 8'h02;
            4'd3:    ks_rcon = 8'h04;
            4'd4:    ks_rcon = 8'h08;
            4'd5:    ks_rcon = 8'h10;
            4'd6:    ks_rcon = 8'h20;
            4'd7:    ks_rcon = 8'h40;
            4'd8:    ks_rcon = 8'h80;
            4'd9:    ks_rcon = 8'h1B;
            4'd10:   ks_rcon = 8'h36;
            default: ks_rcon = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= '0;
            key_reg   <= '0;
            ct_reg    <= '0;
            round_reg <= '0;
            wait_cnt  <= '0;
        end else if (accept) begin
            state_reg <= in_pt ^ in_key;
            key_reg   <= in_key;
            round_reg <= 4'd1;
            wait_cnt  <= '0;
        end else if (fsm == RUN) begin
            if (capture) begin
                state_reg <= dp_result;
                key_reg   <= ks_next;
                wait_cnt  <= '0;
                if (round_reg == 4'd10) begin
                    ct_reg    <= dp_result;
                    round_reg <= '0;
                end else begin
                    round_reg <= round_reg + 4'd1;
                end
            end else begin
                wait_cnt <= wait_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_encrypt_ctrl.sv
// Bench for aes_encrypt_ctrl: two instances (DP_WAIT 0 and 3) with behavioural AES round and
// key-step units, FIPS-197 / SP800-38A vectors, scoreboard on the output handshake.
module tb_aes_encrypt_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [127:0] in_pt     [2];
    logic [127:0] in_key    [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [127:0] out_ct    [2];
    logic [127:0] dp_state  [2];
    logic [127:0] dp_key    [2];
    logic         dp_final  [2];
    logic [127:0] dp_result [2];
    logic [127:0] ks_key    [2];
    logic [7:0]   ks_rcon   [2];
    logic [127:0] ks_next   [2];
    logic [3:0]   round     [2];
    logic         busy      [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_encrypt_ctrl #(.DP_WAIT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_pt(in_pt[0]), .in_key(in_key[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_ct(out_ct[0]), .dp_state(dp_state[0]), .dp_key(dp_key[0]), .dp_final(dp_final[0]),
        .dp_result(dp_result[0]), .ks_key(ks_key[0]), .ks_rcon(ks_rcon[0]), .ks_next(ks_next[0]),
        .round(round[0]), .busy(busy[0])
    );

    aes_encrypt_ctrl #(.DP_WAIT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_pt(in_pt[1]), .in_key(in_key[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_ct(out_ct[1]), .dp_state(dp_state[1]), .dp_key(dp_key[1]), .dp_final(dp_final[1]),
        .dp_result(dp_result[1]), .ks_key(ks_key[1]), .ks_rcon(ks_rcon[1]), .ks_next(ks_next[1]),
        .round(round[1]), .busy(busy[1])
    );

    // ---------------- behavioural AES units ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] e;
        inv = 8'h01;
        e   = 8'hFE;
        for (int i = 7; i >= 0; i--) begin
            inv = gmul(inv, inv);
            if (e[i]) inv = gmul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic fin);
        logic [127:0] sr;
        logic [127:0] mc;
        logic [7:0]   a0, a1, a2, a3;
        sr = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[8*(15-(4*c+r)) +: 8] = sbox(s[8*(15-(4*((c+r)%4)+r)) +: 8]);
        mc = sr;
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = sr[8*(15-4*c) +: 8];
                a1 = sr[8*(14-4*c) +: 8];
                a2 = sr[8*(13-4*c) +: 8];
                a3 = sr[8*(12-4*c) +: 8];
                mc[8*(15-4*c) +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                mc[8*(14-4*c) +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                mc[8*(13-4*c) +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                mc[8*(12-4*c) +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        return mc ^ k;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] n0, n1, n2, n3;
        t = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    always_comb begin
        for (int d = 0; d < 2; d++) ks_next[d] = key_step(ks_key[d], ks_rcon[d]);
    end

    always_comb begin
        for (int d = 0; d < 2; d++) dp_result[d] = aes_round(dp_state[d], dp_key[d], dp_final[d]);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_rcon(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 1; i < int'(r); i++) v = xt(v);
        return v;
    endfunction

    logic [127:0] q0[$];
    logic [127:0] q1[$];
    logic [127:0] cur_exp[2];
    bit           pend[2];
    int           t_acc[2];
    int           t_rnd[2];
    logic [3:0]   prev_round[2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                pend[d] = 1'b0;
                prev_round[d] = '0;
                if (d == 0) q0.delete(); else q1.delete();
            end else begin
                if (in_valid[d] && in_ready[d]) begin
                    if (d == 0) q0.push_back(cur_exp[d]); else q1.push_back(cur_exp[d]);
                    t_acc[d] = cyc;
                    pend[d] = 1'b1;
                end
                if (out_valid[d] && pend[d]) begin
                    check($sformatf("latency_dut%0d", d), 128'(cyc - t_acc[d]),
                          128'(1 + 10 * (d == 0 ? 1 : 4)));
                    pend[d] = 1'b0;
                end
                if (busy[d]) begin
                    check($sformatf("rcon_dut%0d_r%0d", d, round[d]), 128'(ks_rcon[d]),
                          128'(exp_rcon(round[d])));
                    check($sformatf("dp_final_dut%0d_r%0d", d, round[d]), 128'(dp_final[d]),
                          128'(round[d] == 4'd10));
                end
                if (round[d] != prev_round[d]) begin
                    if (prev_round[d] != 0 && round[d] != 0)
                        check($sformatf("round_step_dut%0d", d), 128'(cyc - t_rnd[d]),
                              128'(d == 0 ? 1 : 4));
                    t_rnd[d] = cyc;
                end
                prev_round[d] = round[d];
                if (out_valid[d] && out_ready[d]) begin
                    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                        check($sformatf("unexpected_out_dut%0d", d), out_ct[d], 'x);
                    end else begin
                        check($sformatf("ct_dut%0d", d), out_ct[d],
                              (d == 0) ? q0.pop_front() : q1.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           dut;
    } vec_t;

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    task automatic wait_accept(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(in_valid[d] && in_ready[d]) && n < 100);
        if (n >= 100) check($sformatf("accept_timeout_dut%0d", d), 128'(0), 128'(1));
    endtask

    task automatic wait_handoff(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid[d] && out_ready[d]) && n < 200);
        if (n >= 200) check($sformatf("output_timeout_dut%0d", d), 128'(0), 128'(1));
    endtask

    task automatic run_one(input int d, input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] ct);
        @(posedge clk); #1;
        in_key[d] = key;
        in_pt[d] = pt;
        cur_exp[d] = ct;
        out_ready[d] = 1'b1;
        in_valid[d] = 1'b1;
        wait_accept(d);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        wait_handoff(d);
        @(posedge clk); #1;
    endtask

    vec_t vecs[6];
    int   h;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{K_C1, P_C1, C_C1, 0};
        vecs[1] = '{K_B, P_B, C_B, 0};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 0};
        vecs[3] = '{K_B, 128'h6bc1bee22e409f96e93d7e117393172a,
                    128'h3ad77bb40d7a3660a89ecaf32466ef97, 0};
        vecs[4] = '{K_C1, P_C1, C_C1, 1};
        vecs[5] = '{K_B, P_B, C_B, 1};
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0;
            out_ready[d] = 1'b0;
            in_pt[d] = '0;
            in_key[d] = '0;
            cur_exp[d] = '0;
        end

        // reset values
        #3;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_in_ready_%0d", d), 128'(in_ready[d]), 128'(1));
            check($sformatf("rst_out_valid_%0d", d), 128'(out_valid[d]), 128'(0));
            check($sformatf("rst_busy_%0d", d), 128'(busy[d]), 128'(0));
            check($sformatf("rst_round_%0d", d), 128'(round[d]), 128'(0));
            check($sformatf("rst_out_ct_%0d", d), out_ct[d], 128'(0));
            check($sformatf("rst_dp_final_%0d", d), 128'(dp_final[d]), 128'(0));
            check($sformatf("rst_state_key_%0d", d), dp_state[d] | ks_key[d], 128'(0));
        end
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b1;

        // table-driven vectors on both latencies
        foreach (vecs[i]) run_one(vecs[i].dut, vecs[i].key, vecs[i].pt, vecs[i].ct);

        // consumer stall: output held, new input ignored
        out_ready[0] = 1'b0;
        in_key[0] = K_C1;
        in_pt[0] = P_C1;
        cur_exp[0] = C_C1;
        in_valid[0] = 1'b1;
        wait_accept(0);
        @(posedge clk); #1;
        in_key[0] = K_B;
        in_pt[0] = P_B;
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!out_valid[0] && n < 50);
        end
        for (int i = 0; i < 20; i++) begin
            check("stall_out_valid", 128'(out_valid[0]), 128'(1));
            check("stall_out_ct", out_ct[0], C_C1);
            check("stall_in_ready", 128'(in_ready[0]), 128'(0));
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("after_handoff_in_ready", 128'(in_ready[0]), 128'(1));
        check("after_handoff_out_valid", 128'(out_valid[0]), 128'(0));
        check("after_handoff_ct_retained", out_ct[0], C_C1);

        // asynchronous reset in the middle of round 5
        @(posedge clk); #1;
        in_key[0] = K_C1;
        in_pt[0] = P_C1;
        cur_exp[0] = C_C1;
        in_valid[0] = 1'b1;
        wait_accept(0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (round[0] != 4'd5 && n < 50);
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 128'(out_valid[0]), 128'(0));
        check("abort_round", 128'(round[0]), 128'(0));
        check("abort_in_ready", 128'(in_ready[0]), 128'(1));
        check("abort_busy", 128'(busy[0]), 128'(0));
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b1;
        run_one(0, K_C1, P_C1, C_C1);

        // back-to-back with in_valid held high
        in_key[0] = K_C1;
        in_pt[0] = P_C1;
        cur_exp[0] = C_C1;
        out_ready[0] = 1'b1;
        in_valid[0] = 1'b1;
        wait_accept(0);
        @(posedge clk); #1;
        in_key[0] = K_B;
        in_pt[0] = P_B;
        cur_exp[0] = C_B;
        wait_handoff(0);
        h = cyc;
        wait_accept(0);
        check("b2b_accept_gap", 128'(cyc - h), 128'(1));
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        wait_handoff(0);
        @(negedge clk);

        check("scoreboard_empty_0", 128'(q0.size()), 128'(0));
        check("scoreboard_empty_1", 128'(q1.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
